// File: rtl/fp_pkg.sv
// Shared constants and types for the double -> int32 converter.
// FSM state, rounding modes, field widths, limits and fflags positions.
package fp_pkg;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    localparam int SIGN_W = 1;
    localparam int EXP_W  = 11;
    localparam int FRAC_W = 52;
    localparam int DBL_W  = SIGN_W + EXP_W + FRAC_W;

    localparam int EXP_BIAS = 1023;
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    localparam logic [31:0] S32_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] S32_MIN = 32'h8000_0000;
    localparam logic [31:0] U32_MAX = 32'hFFFF_FFFF;
    localparam logic [32:0] POS_LIM = 33'h0_7FFF_FFFF;
    localparam logic [32:0] NEG_LIM = 33'h0_8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_ROUND,
        ST_DONE
    } state_e;

    localparam int FF_NV = 1;
    localparam int FF_NX = 0;

endpackage

// File: rtl/fp_cvt_w_d_if.sv
// Operand/result handshake bundle for fp_cvt_w_d.
// is_unsigned exists only when FP_CVT_UNSIGNED_EN is defined.
interface fp_cvt_w_d_if;
    import fp_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [DBL_W-1:0] d;
    logic [2:0]       rm;
`ifdef FP_CVT_UNSIGNED_EN
    logic             is_unsigned;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      w;
    logic [1:0]       fflags;

`ifdef FP_CVT_UNSIGNED_EN
    modport master (
        output in_valid, d, rm, is_unsigned, out_ready,
        input  in_ready, out_valid, w, fflags
    );
    modport slave (
        input  in_valid, d, rm, is_unsigned, out_ready,
        output in_ready, out_valid, w, fflags
    );
`else
    modport master (
        output in_valid, d, rm, out_ready,
        input  in_ready, out_valid, w, fflags
    );
    modport slave (
        input  in_valid, d, rm, out_ready,
        output in_ready, out_valid, w, fflags
    );
`endif

endinterface

// File: rtl/fp_round_inc.sv
// Round-increment decision on a magnitude with guard/sticky bits.
// Reserved rm encodings fall back to round-to-nearest-even.
module fp_round_inc
    import fp_pkg::*;
(
    input  logic       sign,
    input  logic       lsb,
    input  logic       guard,
    input  logic       sticky,
    input  logic [2:0] rm,
    output logic       inc
);

    logic lost;

    assign lost = guard | sticky;

    always_comb begin
        inc = 1'b0;
        case (rm)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign & lost;
            RM_RUP:  inc = ~sign & lost;
            RM_RMM:  inc = guard;
            default: inc = guard & (sticky | lsb);
        endcase
    end

endmodule

// File: rtl/fp_cvt_w_d.sv
// fcvt.w.d: IEEE double to int32, IDLE/ALIGN/ROUND/DONE FSM.
// FP_CVT_UNSIGNED_EN adds is_unsigned for fcvt.wu.d.
module fp_cvt_w_d
    import fp_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    fp_cvt_w_d_if.slave   io
);

    localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W+2)'(EXP_BIAS);

    state_e state_q, state_d;
    logic   cap_en, aln_en, rnd_en;

    logic [DBL_W-1:0] d_q;
    logic [2:0]       rm_q;
`ifdef FP_CVT_UNSIGNED_EN
    logic             uns_q;
`endif

    logic        sgn_q, grd_q, stk_q, nan_q, ovf_q;
    logic [31:0] int_q;
    logic [31:0] w_q;
    logic [1:0]  ff_q;

    // ---- FSM ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (io.in_valid) state_d = ST_ALIGN;
            ST_ALIGN: state_d = ST_ROUND;
            ST_ROUND: state_d = ST_DONE;
            ST_DONE:  if (io.out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        io.in_ready  = (state_q == ST_IDLE);
        io.out_valid = (state_q == ST_DONE);
        cap_en       = io.in_ready & io.in_valid;
        aln_en       = (state_q == ST_ALIGN);
        rnd_en       = (state_q == ST_ROUND);
    end

    // ---- ALIGN ----
    logic                    sgn_a;
    logic [EXP_W-1:0]        exp_a;
    logic [FRAC_W-1:0]       frac_a;
    logic signed [EXP_W+1:0] e_a;
    logic [83:0]             sh_a;
    logic [31:0]             int_a;
    logic                    grd_a, stk_a, nan_a, ovf_a;

    assign {sgn_a, exp_a, frac_a} = d_q;
    assign e_a  = $signed({2'b00, exp_a}) - BIAS_S;
    // 52 fraction bits below the binary point after shifting by e
    assign sh_a = {31'b0, 1'b1, frac_a} << e_a[4:0];

    always_comb begin
        int_a = '0;
        grd_a = 1'b0;
        stk_a = 1'b0;
        nan_a = 1'b0;
        ovf_a = 1'b0;
        if (exp_a == EXP_MAX) begin
            nan_a = |frac_a;
            ovf_a = ~|frac_a;
        end else if (exp_a == '0) begin
            stk_a = |frac_a;
        end else if (e_a >= 13'sd32) begin
            ovf_a = 1'b1;
        end else if (e_a >= 13'sd0) begin
            int_a = sh_a[83:52];
            grd_a = sh_a[51];
            stk_a = |sh_a[50:0];
        end else if (e_a == -13'sd1) begin
            grd_a = 1'b1;
            stk_a = |frac_a;
        end else begin
            stk_a = 1'b1;
        end
    end

    // ---- ROUND ----
    logic        inc;
    logic        lost;
    logic [32:0] mag;
    logic [31:0] sres;
    logic [31:0] w_r;
    logic [1:0]  ff_r;

    fp_round_inc u_round_inc (
        .sign   (sgn_q),
        .lsb    (int_q[0]),
        .guard  (grd_q),
        .sticky (stk_q),
        .rm     (rm_q),
        .inc    (inc)
    );

    assign lost = grd_q | stk_q;
    assign mag  = {1'b0, int_q} + {32'b0, inc};
    assign sres = sgn_q ? (~mag[31:0] + 32'd1) : mag[31:0];

    always_comb begin
        w_r  = '0;
        ff_r = '0;
`ifdef FP_CVT_UNSIGNED_EN
        if (uns_q) begin
            if (nan_q || (ovf_q && !sgn_q)) begin
                w_r         = U32_MAX;
                ff_r[FF_NV] = 1'b1;
            end else if (ovf_q) begin
                ff_r[FF_NV] = 1'b1;
            end else if (sgn_q) begin
                // negative input survives only if it rounds to zero
                if (mag != '0) ff_r[FF_NV] = 1'b1;
                else           ff_r[FF_NX] = lost;
            end else if (mag[32]) begin
                w_r         = U32_MAX;
                ff_r[FF_NV] = 1'b1;
            end else begin
                w_r         = mag[31:0];
                ff_r[FF_NX] = lost;
            end
        end else
`endif
        begin
            if (nan_q) begin
                w_r         = S32_MAX;
                ff_r[FF_NV] = 1'b1;
            end else if (ovf_q) begin
                w_r         = sgn_q ? S32_MIN : S32_MAX;
                ff_r[FF_NV] = 1'b1;
            end else if (!sgn_q && mag > POS_LIM) begin
                w_r         = S32_MAX;
                ff_r[FF_NV] = 1'b1;
            end else if (sgn_q && mag > NEG_LIM) begin
                w_r         = S32_MIN;
                ff_r[FF_NV] = 1'b1;
            end else begin
                w_r         = sres;
                ff_r[FF_NX] = lost;
            end
        end
    end

    // ---- datapath registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q   <= '0;
            rm_q  <= RM_RNE;
`ifdef FP_CVT_UNSIGNED_EN
            uns_q <= 1'b0;
`endif
            sgn_q <= 1'b0;
            int_q <= '0;
            grd_q <= 1'b0;
            stk_q <= 1'b0;
            nan_q <= 1'b0;
            ovf_q <= 1'b0;
            w_q   <= '0;
            ff_q  <= '0;
        end else begin
            if (cap_en) begin
                d_q   <= io.d;
                rm_q  <= io.rm;
`ifdef FP_CVT_UNSIGNED_EN
                uns_q <= io.is_unsigned;
`endif
            end
            if (aln_en) begin
                sgn_q <= sgn_a;
                int_q <= int_a;
                grd_q <= grd_a;
                stk_q <= stk_a;
                nan_q <= nan_a;
                ovf_q <= ovf_a;
            end
            if (rnd_en) begin
                w_q  <= w_r;
                ff_q <= ff_r;
            end
        end
    end

    assign io.w      = w_q;
    assign io.fflags = ff_q;

endmodule

// File: tb/tb_fp_cvt_w_d.sv
// Directed-vector bench for fp_cvt_w_d (signed, plus unsigned
// vectors when FP_CVT_UNSIGNED_EN is defined).
`timescale 1ns/1ps
module tb_fp_cvt_w_d;
    import fp_pkg::*;

    localparam logic [1:0] F0 = 2'b00;
    localparam logic [1:0] NX = 2'b01;
    localparam logic [1:0] NV = 2'b10;

    logic clk = 1'b0;
    logic rst_n;
    logic uns_seen;

    always #5 clk = ~clk;

    fp_cvt_w_d_if io ();

    fp_cvt_w_d dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        logic [63:0] d;
        logic [2:0]  rm;
        logic        uns;
        logic [31:0] w;
        logic [1:0]  ff;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [63:0] dv, input logic [2:0] rmv,
                         input logic uns);
        io.d  = dv;
        io.rm = rmv;
        uns_seen = uns;
`ifdef FP_CVT_UNSIGNED_EN
        io.is_unsigned = uns;
`endif
        io.in_valid = 1'b1;
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (io.in_ready) break;
            @(negedge clk);
        end
        if (!io.in_ready) chk({tag, " rdy"}, 64'(io.in_ready), 64'd1);
    endtask

    // counts edges from capture (inclusive) until out_valid
    task automatic wait_done(output int lat);
        lat = 1;
        while (lat < 20) begin
            @(negedge clk);
            if (io.out_valid) break;
            lat++;
        end
    endtask

    task automatic run(input vec_t v);
        int lat;
        @(negedge clk);
        drive(v.d, v.rm, v.uns);
        wait_ready(v.tag);
        @(posedge clk);
        #1 io.in_valid = 1'b0;
        wait_done(lat);
        chk({v.tag, " lat"}, 64'(lat), 64'd3);
        chk({v.tag, " w"}, 64'(io.w), 64'(v.w));
        chk({v.tag, " ff"}, 64'(io.fflags), 64'(v.ff));
        io.out_ready = 1'b1;
        @(posedge clk);
        #1 io.out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        vecs.push_back('{"1.5 rne",   64'h3FF8000000000000, RM_RNE, 1'b0, 32'd2,        NX});
        vecs.push_back('{"2.5 rne",   64'h4004000000000000, RM_RNE, 1'b0, 32'd2,        NX});
        vecs.push_back('{"-2.5 rmm",  64'hC004000000000000, RM_RMM, 1'b0, 32'hFFFFFFFD, NX});
        vecs.push_back('{"2.5 rdn",   64'h4004000000000000, RM_RDN, 1'b0, 32'd2,        NX});
        vecs.push_back('{"2.5 rup",   64'h4004000000000000, RM_RUP, 1'b0, 32'd3,        NX});
        vecs.push_back('{"2.5 rm5",   64'h4004000000000000, 3'd5,   1'b0, 32'd2,        NX});
        vecs.push_back('{"-2.5 rtz",  64'hC004000000000000, RM_RTZ, 1'b0, 32'hFFFFFFFE, NX});
        vecs.push_back('{"-2^31",     64'hC1E0000000000000, RM_RNE, 1'b0, 32'h80000000, F0});
        vecs.push_back('{"2^31",      64'h41E0000000000000, RM_RNE, 1'b0, 32'h7FFFFFFF, NV});
        vecs.push_back('{"nan",       64'h7FF8000000000000, RM_RNE, 1'b0, 32'h7FFFFFFF, NV});
        vecs.push_back('{"-nan",      64'hFFF8000000000000, RM_RNE, 1'b0, 32'h7FFFFFFF, NV});
        vecs.push_back('{"+inf",      64'h7FF0000000000000, RM_RNE, 1'b0, 32'h7FFFFFFF, NV});
        vecs.push_back('{"-inf",      64'hFFF0000000000000, RM_RNE, 1'b0, 32'h80000000, NV});
        vecs.push_back('{"+0",        64'h0000000000000000, RM_RNE, 1'b0, 32'd0,        F0});
        vecs.push_back('{"-0",        64'h8000000000000000, RM_RDN, 1'b0, 32'd0,        F0});
        vecs.push_back('{"sub rup",   64'h0000000000000001, RM_RUP, 1'b0, 32'd1,        NX});
        vecs.push_back('{"-sub rup",  64'h8000000000000001, RM_RUP, 1'b0, 32'd0,        NX});
        vecs.push_back('{"-sub rdn",  64'h8000000000000001, RM_RDN, 1'b0, 32'hFFFFFFFF, NX});
        vecs.push_back('{"max",       64'h41DFFFFFFFC00000, RM_RNE, 1'b0, 32'h7FFFFFFF, F0});
        vecs.push_back('{"max+.5 up", 64'h41DFFFFFFFE00000, RM_RUP, 1'b0, 32'h7FFFFFFF, NV});
        vecs.push_back('{"max+.5 tz", 64'h41DFFFFFFFE00000, RM_RTZ, 1'b0, 32'h7FFFFFFF, NX});
        vecs.push_back('{"min-.5 ne", 64'hC1E0000000100000, RM_RNE, 1'b0, 32'h80000000, NX});
        vecs.push_back('{"min-.5 mm", 64'hC1E0000000100000, RM_RMM, 1'b0, 32'h80000000, NV});
        vecs.push_back('{"0.5 rne",   64'h3FE0000000000000, RM_RNE, 1'b0, 32'd0,        NX});
        vecs.push_back('{"0.5 rmm",   64'h3FE0000000000000, RM_RMM, 1'b0, 32'd1,        NX});
        vecs.push_back('{"0.25 rup",  64'h3FD0000000000000, RM_RUP, 1'b0, 32'd1,        NX});
        vecs.push_back('{"-0.75 rne", 64'hBFE8000000000000, RM_RNE, 1'b0, 32'hFFFFFFFF, NX});
        vecs.push_back('{"1e300",     64'h7E37E43C8800759C, RM_RNE, 1'b0, 32'h7FFFFFFF, NV});
`ifdef FP_CVT_UNSIGNED_EN
        vecs.push_back('{"u -0.5 tz", 64'hBFE0000000000000, RM_RTZ, 1'b1, 32'd0,        NX});
        vecs.push_back('{"u -0.5 dn", 64'hBFE0000000000000, RM_RDN, 1'b1, 32'd0,        NV});
        vecs.push_back('{"u -1.0",    64'hBFF0000000000000, RM_RNE, 1'b1, 32'd0,        NV});
        vecs.push_back('{"u 2^32-1",  64'h41EFFFFFFFE00000, RM_RNE, 1'b1, 32'hFFFFFFFF, F0});
        vecs.push_back('{"u 2^32",    64'h41F0000000000000, RM_RNE, 1'b1, 32'hFFFFFFFF, NV});
        vecs.push_back('{"u 2^31",    64'h41E0000000000000, RM_RNE, 1'b1, 32'h80000000, F0});
        vecs.push_back('{"u nan",     64'hFFF8000000000000, RM_RNE, 1'b1, 32'hFFFFFFFF, NV});
        vecs.push_back('{"u -inf",    64'hFFF0000000000000, RM_RNE, 1'b1, 32'd0,        NV});
        vecs.push_back('{"u top up",  64'h41EFFFFFFFF00000, RM_RUP, 1'b1, 32'hFFFFFFFF, NV});
        vecs.push_back('{"u top tz",  64'h41EFFFFFFFF00000, RM_RTZ, 1'b1, 32'hFFFFFFFF, NX});
`endif

        rst_n        = 1'b0;
        io.in_valid  = 1'b0;
        io.out_ready = 1'b0;
        io.d         = '0;
        io.rm        = RM_RNE;
        uns_seen     = 1'b0;
`ifdef FP_CVT_UNSIGNED_EN
        io.is_unsigned = 1'b0;
`endif
        #12;
        chk("rst in_ready", 64'(io.in_ready), 64'd1);
        chk("rst out_valid", 64'(io.out_valid), 64'd0);
        chk("rst w", 64'(io.w), 64'd0);
        chk("rst ff", 64'(io.fflags), 64'(F0));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run(vecs[i]);

        // backpressure: result held, second operand waits
        @(negedge clk);
        drive(64'h3FF8000000000000, RM_RNE, 1'b0);
        wait_ready("stall");
        @(posedge clk);
        #1 drive(64'hBFF8000000000000, RM_RNE, 1'b0);
        wait_done(lat);
        chk("stall lat", 64'(lat), 64'd3);
        for (int k = 0; k < 5; k++) begin
            chk("stall w", 64'(io.w), 64'd2);
            chk("stall ff", 64'(io.fflags), 64'(NX));
            chk("stall rdy", 64'(io.in_ready), 64'd0);
            chk("stall ov", 64'(io.out_valid), 64'd1);
            @(negedge clk);
        end
        io.out_ready = 1'b1;
        @(posedge clk);
        #1 io.out_ready = 1'b0;
        @(negedge clk);
        chk("2nd rdy", 64'(io.in_ready), 64'd1);
        @(posedge clk);
        #1 io.in_valid = 1'b0;
        wait_done(lat);
        chk("2nd lat", 64'(lat), 64'd3);
        chk("2nd w", 64'(io.w), 64'hFFFFFFFE);
        chk("2nd ff", 64'(io.fflags), 64'(NX));
        io.out_ready = 1'b1;
        @(posedge clk);
        #1 io.out_ready = 1'b0;

        // reset while in ROUND
        @(negedge clk);
        drive(64'h4014000000000000, RM_RTZ, 1'b0);
        wait_ready("rst op");
        @(posedge clk);
        #1 io.in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid rst rdy", 64'(io.in_ready), 64'd1);
        chk("mid rst ov", 64'(io.out_valid), 64'd0);
        chk("mid rst w", 64'(io.w), 64'd0);
        chk("mid rst ff", 64'(io.fflags), 64'(F0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post rst ov", 64'(io.out_valid), 64'd0);
        end
        run('{"post rst 5.0", 64'h4014000000000000, RM_RTZ, 1'b0, 32'd5, F0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
